// File: rtl/pipelined_hcla_addsub_pkg.sv
// Shared definitions for the pipelined hierarchical carry-lookahead adder/subtractor.
package hcla_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  function automatic int unsigned hcla_num_groups(input int unsigned w, input int unsigned blk);
    return w / blk;
  endfunction

endpackage

// File: rtl/pipelined_hcla_addsub_if.sv
// Operand/result handshake bundle; slave is the adder side, master the producer/consumer side.
interface pipelined_hcla_addsub_if
  import hcla_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             cin;
  op_e              op;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic [TAG_W-1:0] tag_out;

  modport slave (
    input  in_valid, a, b, cin, op, tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg, tag_out
  );

  modport master (
    output in_valid, a, b, cin, op, tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg, tag_out
  );

endinterface

// File: rtl/pipelined_hcla_addsub_cla_group.sv
// Combinational BLK-bit lookahead group: group G/P plus sums for carry-in 0 and carry-in 1.
module cla_group #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] i_a,
  input  logic [BLK-1:0] i_b,
  output logic           o_g,
  output logic           o_p,
  output logic [BLK-1:0] o_sum0,
  output logic [BLK-1:0] o_sum1
);

  logic [BLK-1:0] w_g;
  logic [BLK-1:0] w_p;
  logic [BLK:0]   w_c0;
  logic [BLK-1:0] w_c1;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c0    = '0;
    w_c1    = '0;
    w_c1[0] = 1'b1;
    for (int j = 0; j < BLK; j++) begin
      w_c0[j+1] = w_g[j] | (w_p[j] & w_c0[j]);
    end
    for (int j = 0; j < BLK - 1; j++) begin
      w_c1[j+1] = w_g[j] | (w_p[j] & w_c1[j]);
    end
  end

  // Carry out with carry-in 0 is exactly the group generate.
  assign o_g    = w_c0[BLK];
  assign o_p    = &w_p;
  assign o_sum0 = w_p ^ w_c0[BLK-1:0];
  assign o_sum1 = w_p ^ w_c1;

endmodule

// File: rtl/pipelined_hcla_addsub.sv
// Two-stage pipelined hierarchical CLA adder/subtractor with flags, tag and valid/ready backpressure.
module pipelined_hcla_addsub
  import hcla_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned BLK   = 4,
  parameter int unsigned TAG_W = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_hcla_addsub_if.slave  io_bus
);

  localparam int unsigned NG = hcla_num_groups(W, BLK);

  logic                    w_adv1, w_adv2;
  logic [W-1:0]            w_b_eff;
  logic                    w_c0;
  logic [NG-1:0]           w_g, w_p;
  logic [NG-1:0][BLK-1:0]  w_s0, w_s1;

  logic                    r_v1;
  logic [NG-1:0]           r_g1, r_p1;
  logic [NG-1:0][BLK-1:0]  r_s0_1, r_s1_1;
  logic                    r_c0_1, r_a_msb1, r_b_msb1;
  logic [TAG_W-1:0]        r_tag1;

  logic [NG:0]             w_gc;
  logic                    w_gg, w_pp;
  logic [W-1:0]            w_sum;

  logic                    r_v2;
  logic [W-1:0]            r_sum2;
  logic                    r_cout2, r_ovf2, r_zero2, r_neg2;
  logic [TAG_W-1:0]        r_tag2;

  // S2 may advance when empty even under backpressure, so bubbles collapse.
  assign w_adv2          = !r_v2 || io_bus.out_ready;
  assign w_adv1          = !r_v1 || w_adv2;
  assign io_bus.in_ready = w_adv1;

  always_comb begin
    w_b_eff = io_bus.b;
    w_c0    = 1'b0;
    unique case (io_bus.op)
      OP_ADD: w_c0 = 1'b0;
      OP_SUB: begin
        w_b_eff = ~io_bus.b;
        w_c0    = 1'b1;
      end
      OP_ADC: w_c0 = io_bus.cin;
      OP_SBB: begin
        w_b_eff = ~io_bus.b;
        w_c0    = io_bus.cin;
      end
      default: w_c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.BLK(BLK)) u_grp (
      .i_a    (io_bus.a[k*BLK +: BLK]),
      .i_b    (w_b_eff[k*BLK +: BLK]),
      .o_g    (w_g[k]),
      .o_p    (w_p[k]),
      .o_sum0 (w_s0[k]),
      .o_sum1 (w_s1[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_g1     <= '0;
      r_p1     <= '0;
      r_s0_1   <= '0;
      r_s1_1   <= '0;
      r_c0_1   <= 1'b0;
      r_a_msb1 <= 1'b0;
      r_b_msb1 <= 1'b0;
      r_tag1   <= '0;
    end else if (w_adv1) begin
      r_v1 <= io_bus.in_valid;
      if (io_bus.in_valid) begin
        r_g1     <= w_g;
        r_p1     <= w_p;
        r_s0_1   <= w_s0;
        r_s1_1   <= w_s1;
        r_c0_1   <= w_c0;
        r_a_msb1 <= io_bus.a[W-1];
        r_b_msb1 <= w_b_eff[W-1];
        r_tag1   <= io_bus.tag;
      end
    end
  end

  // Second-level lookahead: prefix G/P over groups 0..k-1 combined with c0.
  always_comb begin
    w_gc    = '0;
    w_gc[0] = r_c0_1;
    w_gg    = 1'b0;
    w_pp    = 1'b1;
    w_sum   = '0;
    for (int k = 0; k < NG; k++) begin
      w_gg      = r_g1[k] | (r_p1[k] & w_gg);
      w_pp      = r_p1[k] & w_pp;
      w_gc[k+1] = w_gg | (w_pp & r_c0_1);
    end
    for (int k = 0; k < NG; k++) begin
      w_sum[k*BLK +: BLK] = w_gc[k] ? r_s1_1[k] : r_s0_1[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_sum2  <= '0;
      r_cout2 <= 1'b0;
      r_ovf2  <= 1'b0;
      r_zero2 <= 1'b0;
      r_neg2  <= 1'b0;
      r_tag2  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum2  <= w_sum;
        r_cout2 <= w_gc[NG];
        r_ovf2  <= (r_a_msb1 == r_b_msb1) && (w_sum[W-1] != r_a_msb1);
        r_zero2 <= (w_sum == '0);
        r_neg2  <= w_sum[W-1];
        r_tag2  <= r_tag1;
      end
    end
  end

  assign io_bus.out_valid = r_v2;
  assign io_bus.sum       = r_sum2;
  assign io_bus.cout      = r_cout2;
  assign io_bus.ovf       = r_ovf2;
  assign io_bus.zero      = r_zero2;
  assign io_bus.neg       = r_neg2;
  assign io_bus.tag_out   = r_tag2;

endmodule

// File: tb/tb_pipelined_hcla_addsub.sv
// Scoreboard bench: directed cases, stalled stream, mid-flight reset and random sweeps of three sizes.
module tb_pipelined_hcla_addsub;
  import hcla_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 4;

  typedef struct {
    longint unsigned sum;
    bit              cout, ovf, zero, neg;
    logic [TW-1:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rst_sw_n;
  int   checks = 0, failures = 0;
  int   n_pop = 0;
  int   ready_mode = 0;
  bit   ready_hold = 1'b1;
  bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit   sw_done [2] = '{1'b0, 1'b0};
  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_hcla_addsub_if #(.W(W), .TAG_W(TW)) bus ();
  pipelined_hcla_addsub #(.W(W), .BLK(4), .TAG_W(TW)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  function automatic longint sext(input int w, input longint unsigned x);
    longint unsigned one = 1;
    if (((x >> (w - 1)) & one) != 0) return longint'(x) - longint'(one << w);
    return longint'(x);
  endfunction

  // Reference: {cout,sum} = a + b' + c0 with plain integer arithmetic; ovf from true signed sum.
  function automatic exp_t model(input int w, input longint unsigned a, input longint unsigned b,
                                 input op_e op, input bit cin, input logic [TW-1:0] tag);
    exp_t e;
    longint unsigned one = 1;
    longint unsigned m = (one << w) - 1;
    longint unsigned bp = (op == OP_SUB || op == OP_SBB) ? (~b & m) : (b & m);
    longint unsigned c0 = (op == OP_ADD) ? 0 : (op == OP_SUB) ? 1 : longint'(cin);
    longint unsigned full = (a & m) + bp + c0;
    e.sum  = full & m;
    e.cout = ((full >> w) & one) != 0;
    e.ovf  = (sext(w, a & m) + sext(w, bp) + longint'(c0)) != sext(w, e.sum);
    e.zero = (e.sum == 0);
    e.neg  = ((e.sum >> (w - 1)) & one) != 0;
    e.tag  = tag;
    return e;
  endfunction

  task automatic check_res(input string nm, input exp_t e, input longint unsigned sum,
                           input bit cout, input bit ovf, input bit zero, input bit neg,
                           input logic [TW-1:0] tag);
    checks++;
    if (sum != e.sum || cout != e.cout || ovf != e.ovf || zero != e.zero || neg != e.neg
        || tag != e.tag) begin
      failures++;
      $display("FAIL %s: got sum=%0h c=%b v=%b z=%b n=%b tag=%0h, want sum=%0h c=%b v=%b z=%b n=%b tag=%0h",
               nm, sum, cout, ovf, zero, neg, tag, e.sum, e.cout, e.ovf, e.zero, e.neg, e.tag);
    end
  endtask

  task automatic check_bit(input string nm, input bit got, input bit want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %b, want %b", nm, got, want);
    end
  endtask

  // out_ready driver: 0 = hold ready_hold, 1 = pattern 1,0,0,1, 2 = random 75% ready
  initial begin
    int pcnt = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: begin
          bus.out_ready = pat[pcnt % 4];
          pcnt++;
        end
        2:       bus.out_ready = ($urandom_range(3) != 0);
        default: bus.out_ready = ready_hold;
      endcase
    end
  end

  // Monitor: pops on every delivered result and checks that stalled outputs hold.
  initial begin
    bit   stalled = 1'b0;
    exp_t snap, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check_bit("stall_valid_hold", bus.out_valid, 1'b1);
          check_res("stall_data_hold", snap, 64'(bus.sum), bus.cout, bus.ovf, bus.zero, bus.neg,
                    bus.tag_out);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got tag=%0h sum=%0h, want no result", bus.tag_out,
                     bus.sum);
          end else begin
            e = q.pop_front();
            n_pop++;
            check_res("result", e, 64'(bus.sum), bus.cout, bus.ovf, bus.zero, bus.neg,
                      bus.tag_out);
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        snap.sum  = 64'(bus.sum);
        snap.cout = bus.cout;
        snap.ovf  = bus.ovf;
        snap.zero = bus.zero;
        snap.neg  = bus.neg;
        snap.tag  = bus.tag_out;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input op_e op, input bit cin,
                      input logic [TW-1:0] tag);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.cin = cin;
    bus.tag = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      q.push_back(model(W, 64'(a), 64'(b), op, cin, tag));
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results outstanding, want 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int pop0;
    rst_n = 1'b0;
    rst_sw_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = OP_ADD;
    bus.cin = 1'b0;
    bus.tag = '0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0
        || bus.zero !== 1'b0 || bus.neg !== 1'b0 || bus.tag_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b sum=%0h c=%b o=%b z=%b n=%b tag=%0h, want all 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg, bus.tag_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rst_sw_n = 1'b1;
    @(negedge clk);
    check_bit("reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Latency: accept edge, then out_valid only after the second edge.
    send(16'h00A0, 16'h00A0, OP_ADD, 1'b0, 4'h1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_bit("latency_early", bus.out_valid, 1'b0);
    @(negedge clk);
    check_bit("latency_2cyc", bus.out_valid, 1'b1);
    @(posedge clk); #1;

    send(16'h00A0, 16'hFF5F, OP_ADC, 1'b1, 4'h2);
    send(16'h8000, 16'h0001, OP_SUB, 1'b0, 4'h3);
    send(16'h0000, 16'h0001, OP_SBB, 1'b1, 4'h4);
    send(16'h0000, 16'h0001, OP_SBB, 1'b0, 4'h5);
    send(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 4'h6);
    idle();
    drain();

    // Back-to-back stream under 1,0,0,1 backpressure.
    pop0 = n_pop;
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      send(16'($urandom), 16'($urandom), op_e'($urandom_range(3)), 1'($urandom_range(1)), 4'(t));
    end
    idle();
    ready_mode = 0;
    ready_hold = 1'b1;
    drain();
    checks++;
    if (n_pop - pop0 != 8) begin
      failures++;
      $display("FAIL stream_count: got %0d results, want 8", n_pop - pop0);
    end

    // Reset with two beats in flight.
    ready_hold = 1'b0;
    idle();
    idle();
    send(16'h1234, 16'h1111, OP_ADD, 1'b0, 4'hC);
    send(16'h4321, 16'h0101, OP_SUB, 1'b0, 4'hD);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_bit("pre_reset_valid", bus.out_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.tag_out !== '0) begin
      failures++;
      $display("FAIL reset_midop: got v=%b sum=%0h tag=%0h, want 0 0 0", bus.out_valid, bus.sum,
               bus.tag_out);
    end
    ready_hold = 1'b1;
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0F0F, 16'h0101, OP_ADD, 1'b0, 4'h9);
    idle();
    drain();

    // Random traffic with random gaps and backpressure.
    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) idle();
      send(16'($urandom), 16'($urandom), op_e'($urandom_range(3)), 1'($urandom_range(1)),
           4'($urandom_range(15)));
    end
    idle();
    ready_mode = 0;
    ready_hold = 1'b1;
    drain();

    for (int i = 0; i < 50000 && !(sw_done[0] && sw_done[1]); i++) @(negedge clk);
    checks++;
    if (!(sw_done[0] && sw_done[1])) begin
      failures++;
      $display("FAIL sweep_timeout: got done=%b%b, want 11", sw_done[1], sw_done[0]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Parameter sweep: W=32/BLK=8 and W=8/BLK=8, random ops under random backpressure.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned GW = (g == 0) ? 32 : 8;
    pipelined_hcla_addsub_if #(.W(GW), .TAG_W(TW)) sbus ();
    pipelined_hcla_addsub #(.W(GW), .BLK(8), .TAG_W(TW)) u_dut (
      .clk    (clk),
      .rst_n  (rst_sw_n),
      .io_bus (sbus)
    );
    exp_t sq[$];

    initial begin
      sbus.out_ready = 1'b1;
      forever begin
        @(posedge clk); #1;
        sbus.out_ready = ($urandom_range(3) != 0);
      end
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (rst_sw_n && sbus.out_valid && sbus.out_ready) begin
          if (sq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sweep%0d_unexpected: got tag=%0h, want no result", GW, sbus.tag_out);
          end else begin
            e = sq.pop_front();
            check_res($sformatf("sweep%0d_result", GW), e, 64'(sbus.sum), sbus.cout, sbus.ovf,
                      sbus.zero, sbus.neg, sbus.tag_out);
          end
        end
      end
    end

    initial begin
      bit ok;
      sbus.in_valid = 1'b0;
      sbus.a = '0;
      sbus.b = '0;
      sbus.op = OP_ADD;
      sbus.cin = 1'b0;
      sbus.tag = '0;
      wait (rst_sw_n);
      @(posedge clk); #1;
      for (int i = 0; i < 10000; i++) begin
        sbus.a = GW'($urandom);
        sbus.b = GW'($urandom);
        sbus.op = op_e'($urandom_range(3));
        sbus.cin = 1'($urandom_range(1));
        sbus.tag = 4'($urandom_range(15));
        sbus.in_valid = 1'b1;
        ok = 1'b0;
        for (int j = 0; j < 200; j++) begin
          @(negedge clk);
          if (sbus.in_ready) begin
            ok = 1'b1;
            break;
          end
        end
        if (ok) begin
          sq.push_back(model(GW, 64'(sbus.a), 64'(sbus.b), sbus.op, sbus.cin, sbus.tag));
        end else begin
          checks++;
          failures++;
          $display("FAIL sweep%0d_accept_timeout: got in_ready=0, want 1", GW);
        end
        @(posedge clk); #1;
      end
      sbus.in_valid = 1'b0;
      for (int j = 0; j < 300 && sq.size() > 0; j++) @(negedge clk);
      checks++;
      if (sq.size() != 0) begin
        failures++;
        $display("FAIL sweep%0d_drain: got %0d outstanding, want 0", GW, sq.size());
      end
      sw_done[g] = 1'b1;
    end
  end

endmodule
